// File: rtl/vtc_pkg.sv
// Shared timing constants, FSM state type and decode helpers for the video timing controller.
package vtc_pkg;

    localparam logic [8:0] HTOTAL        = 9'd320;
    localparam logic [8:0] HACT          = 9'd256;
    localparam logic [8:0] HS_START      = 9'd280;
    localparam logic [8:0] HS_END        = 9'd304;
    localparam logic [8:0] VACT          = 9'd240;
    localparam logic [8:0] VTOTAL_NTSC   = 9'd262;
    localparam logic [8:0] VTOTAL_PAL    = 9'd312;
    localparam logic [8:0] VS_START_NTSC = 9'd244;
    localparam logic [8:0] VS_END_NTSC   = 9'd247;
    localparam logic [8:0] VS_START_PAL  = 9'd270;
    localparam logic [8:0] VS_END_PAL    = 9'd273;

    typedef enum logic {StInit, StRun} vtc_state_e;

    function automatic logic [8:0] vlast(input logic pal);
        return pal ? (VTOTAL_PAL - 9'd1) : (VTOTAL_NTSC - 9'd1);
    endfunction

    function automatic logic vsync_dec(input logic [8:0] v, input logic pal);
        if (pal) begin
            return (v >= VS_START_PAL) && (v < VS_END_PAL);
        end
        return (v >= VS_START_NTSC) && (v < VS_END_NTSC);
    endfunction

endpackage

// File: rtl/video_timing_ctrl_if.sv
// Bundle of mode inputs and timing outputs for video_timing_ctrl.
// frame_cnt is present only when VTC_FRAME_CNT_EN is defined.
interface video_timing_ctrl_if;

    logic       pal;
    logic       scandouble;
    logic       ce_pix;
    logic [8:0] hcnt;
    logic [8:0] vcnt;
    logic       HBlank;
    logic       HSync;
    logic       VBlank;
    logic       VSync;
    logic       frame_start;

`ifdef VTC_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    modport master (
        input  pal, scandouble,
        output ce_pix, hcnt, vcnt, HBlank, HSync, VBlank, VSync, frame_start, frame_cnt
    );
    modport slave (
        output pal, scandouble,
        input  ce_pix, hcnt, vcnt, HBlank, HSync, VBlank, VSync, frame_start, frame_cnt
    );
`else
    modport master (
        input  pal, scandouble,
        output ce_pix, hcnt, vcnt, HBlank, HSync, VBlank, VSync, frame_start
    );
    modport slave (
        output pal, scandouble,
        input  ce_pix, hcnt, vcnt, HBlank, HSync, VBlank, VSync, frame_start
    );
`endif

endinterface

// File: rtl/vtc_ce_gen.sv
// 2-bit pixel-enable prescaler: ce strobes once every 4 clocks, or every 2 when div2 is set.
module vtc_ce_gen (
    input  logic clk,
    input  logic reset_n,
    input  logic div2,
    input  logic restart,
    output logic ce
);

    logic [1:0] cnt_q, cnt_d;
    logic [1:0] last;

    assign last = div2 ? 2'd1 : 2'd3;
    assign ce   = (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q + 2'd1;
        if (restart || ce) begin
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator: pixel enable, h/v counters and registered blank/sync decodes.
// Optional VTC_FRAME_CNT_EN adds a 16-bit wrapping frame counter.
module video_timing_ctrl
    import vtc_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    video_timing_ctrl_if.master bus
);

    vtc_state_e state_q, state_d;
    logic [8:0] hcnt_q, hcnt_d;
    logic [8:0] vcnt_q, vcnt_d;
    logic       pal_q, pal_d;
    logic       sd_q, sd_d;
    logic       ce_pix_q, frame_start_q;
    logic       hblank_q, hsync_q, vblank_q, vsync_q;
    logic       ce_raw, adv, frame_wrap, load_shadow, restart;

    vtc_ce_gen u_ce_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .div2    (sd_q),
        .restart (restart),
        .ce      (ce_raw)
    );

    always_comb begin
        state_d     = state_q;
        load_shadow = 1'b0;
        restart     = 1'b0;
        unique case (state_q)
            StInit: begin
                state_d     = StRun;
                load_shadow = 1'b1;
                restart     = 1'b1;
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase

        adv        = (state_q == StRun) && ce_raw;
        frame_wrap = adv && (hcnt_q == HTOTAL - 9'd1) && (vcnt_q == vlast(pal_q));

        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (adv) begin
            if (hcnt_q == HTOTAL - 9'd1) begin
                hcnt_d = 9'd0;
                vcnt_d = (vcnt_q == vlast(pal_q)) ? 9'd0 : vcnt_q + 9'd1;
            end else begin
                hcnt_d = hcnt_q + 9'd1;
            end
        end

        // Mode inputs only take effect at a frame boundary; a rate change restarts the prescaler.
        if (frame_wrap) begin
            load_shadow = 1'b1;
            restart     = (bus.scandouble != sd_q);
        end
        pal_d = load_shadow ? bus.pal : pal_q;
        sd_d  = load_shadow ? bus.scandouble : sd_q;
    end

    // Decodes are taken from next-state counters so they change on the same edge as hcnt/vcnt.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StInit;
            hcnt_q        <= 9'd0;
            vcnt_q        <= 9'd0;
            pal_q         <= 1'b0;
            sd_q          <= 1'b0;
            ce_pix_q      <= 1'b0;
            frame_start_q <= 1'b0;
            hblank_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vblank_q      <= 1'b0;
            vsync_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            pal_q         <= pal_d;
            sd_q          <= sd_d;
            ce_pix_q      <= adv;
            frame_start_q <= frame_wrap;
            hblank_q      <= (hcnt_d >= HACT);
            hsync_q       <= (hcnt_d >= HS_START) && (hcnt_d < HS_END);
            vblank_q      <= (vcnt_d >= VACT);
            vsync_q       <= vsync_dec(vcnt_d, pal_d);
        end
    end

    assign bus.ce_pix      = ce_pix_q;
    assign bus.hcnt        = hcnt_q;
    assign bus.vcnt        = vcnt_q;
    assign bus.HBlank      = hblank_q;
    assign bus.HSync       = hsync_q;
    assign bus.VBlank      = vblank_q;
    assign bus.VSync       = vsync_q;
    assign bus.frame_start = frame_start_q;

`ifdef VTC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt_q <= 16'd0;
        end else if (frame_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule
